// File: rtl/top_level_nios2_qsys_0_div_cell.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Start is taken only in IDLE outside the done cycle; done pulses WIDTH+1 clocks after start.
module top_level_nios2_qsys_0_div_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A_div_src1,
  input  logic [WIDTH-1:0] A_div_src2,
  input  logic             A_div_signed,
  input  logic             A_div_start,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             neg_q, neg_r, div0;

  logic             accept;
  logic             src1_neg, src2_neg, src2_zero;
  logic [WIDTH:0]   rem_sh, trial;
  logic             take;
  logic [WIDTH-1:0] fix_q, fix_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DIV;
      DIV:     if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == IDLE) && A_div_start && !A_div_done;
    src1_neg  = A_div_signed & A_div_src1[WIDTH-1];
    src2_neg  = A_div_signed & A_div_src2[WIDTH-1];
    src2_zero = (A_div_src2 == '0);
    rem_sh    = {rem, quo[WIDTH-1]};
    trial     = rem_sh - {1'b0, dvs};
    // A zero divisor always "fits", so quotient saturates to all ones.
    take      = ~trial[WIDTH] | div0;
    fix_q     = (neg_q & ~div0) ? -quo : quo;
    fix_r     = (neg_r & ~div0) ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count           <= '0;
      rem             <= '0;
      quo             <= '0;
      dvs             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      div0            <= 1'b0;
      A_div_busy      <= 1'b0;
      A_div_done      <= 1'b0;
      A_div_quotient  <= '0;
      A_div_remainder <= '0;
    end else begin
      A_div_done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          // On divide by zero the raw dividend shifts through and lands as the remainder.
          quo        <= (src1_neg && !src2_zero) ? -A_div_src1 : A_div_src1;
          dvs        <= src2_neg ? -A_div_src2 : A_div_src2;
          rem        <= '0;
          neg_q      <= src1_neg ^ src2_neg;
          neg_r      <= src1_neg;
          div0       <= src2_zero;
          count      <= CW'(WIDTH - 1);
          A_div_busy <= 1'b1;
        end
        DIV: begin
          rem   <= take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo   <= {quo[WIDTH-2:0], take};
          count <= count - 1'b1;
        end
        FIX: begin
          A_div_quotient  <= fix_q;
          A_div_remainder <= fix_r;
          A_div_done      <= 1'b1;
          A_div_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
